// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 framing constants and the state encoding
// used by both the transmitter and the receiver.
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] DATA  = 2'b11;
    localparam logic [1:0] STOP  = 2'b10;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StStart = START,
        StData  = DATA,
        StStop  = STOP
    } uart_state_e;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rx pin into the clk domain and flags its falling edges.
// Every flop resets to the idle line level so reset never produces a false edge.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s_d_q, rx_s_d_d;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], rx};
        rx_s_d_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= {SYNC_STAGES{IDLE_LEVEL}};
            rx_s_d_q <= IDLE_LEVEL;
        end else begin
            sync_q   <= sync_d;
            rx_s_d_q <= rx_s_d_d;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = rx_s_d_q & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with runtime baud divisor, mid-bit sampling and a one-deep
// holding register with valid/read_ack handshake, framing-error and overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_en,
    input  logic        rx,
    input  logic [31:0] clk_count_bit,
    output logic [7:0]  data,
    output logic        valid,
    input  logic        read_ack,
    output logic        busy_flag,
    output logic        frame_err,
    output logic        overrun
);

    logic rx_s;
    logic fall;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    uart_state_e state_q, state_d;
    logic [31:0] clk_count_q, clk_count_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    logic [31:0] half_last;
    logic [31:0] bit_last;
    logic        load;

    assign half_last = (clk_count_bit >> 1) - 32'd1;
    assign bit_last  = clk_count_bit - 32'd1;

    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        load        = 1'b0;

        case (state_q)
            StIdle: begin
                clk_count_d = 32'd0;
                bit_idx_d   = 3'd0;
                if (fall && rx_en) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (clk_count_q == half_last) begin
                    clk_count_d = 32'd0;
                    // A high line at mid-start is a glitch, not a frame.
                    state_d     = rx_s ? StIdle : StData;
                end else begin
                    clk_count_d = clk_count_q + 32'd1;
                end
            end
            StData: begin
                if (clk_count_q == bit_last) begin
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    clk_count_d        = 32'd0;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = StStop;
                    end
                end else begin
                    clk_count_d = clk_count_q + 32'd1;
                end
            end
            StStop: begin
                if (clk_count_q == bit_last) begin
                    clk_count_d = 32'd0;
                    state_d     = StIdle;
                    if (rx_s == IDLE_LEVEL) begin
                        load = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_count_d = clk_count_q + 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (read_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        // A load in the same cycle as read_ack wins and is not an overrun.
        if (load) begin
            data_d      = shift_q;
            valid_d     = 1'b1;
            frame_err_d = 1'b0;
            if (valid_q && !read_ack) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            clk_count_q <= 32'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy_flag = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a timestamp-based frame model predicts every output each
// cycle from the recorded line history; directed frames exercise the handshake.
module tb_uart_rx;

    localparam int SYNC = 2;
    localparam int HIST = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_en;
    logic        rx;
    logic [31:0] clk_count_bit;
    logic [7:0]  data;
    logic        valid;
    logic        read_ack = 1'b0;
    logic        busy_flag;
    logic        frame_err;
    logic        overrun;

    uart_rx #(
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_en        (rx_en),
        .rx           (rx),
        .clk_count_bit(clk_count_bit),
        .data         (data),
        .valid        (valid),
        .read_ack     (read_ack),
        .busy_flag    (busy_flag),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int n_bit = 16;
    int half  = 8;

    // hist[i] is the line value driven between edge i and edge i+1.
    logic hist [0:HIST-1];
    int   e_cnt    = 0;
    int   rst_edge = 0;
    logic m_live   = 1'b0;

    logic [7:0] m_data;
    logic       m_valid, m_ferr, m_ovr, m_busy;
    int         f_p, f_e0;

    int   ack_edge  = -1;
    int   sent_p    = 0;
    int   last_rise = -1;
    logic prev_valid = 1'b0;
    logic busy_seen  = 1'b0;

    function automatic logic line_at(input int i);
        if (i < rst_edge || i < 0 || i >= HIST) return 1'b1;
        return hist[i];
    endfunction

    // Frame model: a frame starts at the edge its falling line edge emerges from
    // the synchroniser, and its samples sit at start + half + k*n_bit.
    initial begin
        logic       load, bad, old_valid;
        logic [7:0] m_byte;
        forever begin
            @(posedge clk);
            e_cnt = e_cnt + 1;
            if (e_cnt - 1 < HIST) hist[e_cnt-1] = rx;
            if (reset) begin
                m_data = 8'd0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
                m_busy = 1'b0; rst_edge = e_cnt; m_live = 1'b1;
            end else if (m_live) begin
                load = 1'b0; bad = 1'b0; old_valid = m_valid; m_byte = 8'd0;
                if (m_busy) begin
                    if (e_cnt == f_e0 + half && line_at(f_p + half)) begin
                        m_busy = 1'b0;
                    end else if (e_cnt == f_e0 + half + 9 * n_bit) begin
                        m_busy = 1'b0;
                        if (line_at(f_p + half + 9 * n_bit)) begin
                            load = 1'b1;
                            for (int k = 0; k < 8; k++)
                                m_byte[k] = line_at(f_p + half + (k + 1) * n_bit);
                        end else begin
                            bad = 1'b1;
                        end
                    end
                end else if (rx_en && !line_at(e_cnt - SYNC - 1) && line_at(e_cnt - SYNC - 2)) begin
                    m_busy = 1'b1;
                    f_p    = e_cnt - SYNC - 1;
                    f_e0   = e_cnt;
                end
                if (read_ack && old_valid) begin
                    m_valid = 1'b0; m_ovr = 1'b0;
                end
                if (load) begin
                    if (old_valid && !read_ack) m_ovr = 1'b1;
                    m_data = m_byte; m_valid = 1'b1; m_ferr = 1'b0;
                end
                if (bad) m_ferr = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                n_cmp = n_cmp + 1;
                if ({data, valid, frame_err, overrun, busy_flag} !==
                    {m_data, m_valid, m_ferr, m_ovr, m_busy}) begin
                    n_bad = n_bad + 1;
                    $display("FAIL cycle_%0d data/valid/ferr/ovr/busy got %h/%b/%b/%b/%b required %h/%b/%b/%b/%b",
                             e_cnt, data, valid, frame_err, overrun, busy_flag,
                             m_data, m_valid, m_ferr, m_ovr, m_busy);
                end
                if (valid === 1'b1 && prev_valid !== 1'b1) last_rise = e_cnt;
                prev_valid = valid;
                if (busy_flag === 1'b1) busy_seen = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            read_ack = (e_cnt + 1 == ack_edge);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        sent_p = e_cnt;
        rx = 1'b0;
        wait_cycles(n_bit);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(n_bit);
        end
        rx = stop_bit;
        wait_cycles(n_bit);
        rx = 1'b1;
    endtask

    task automatic ack_pulse();
        ack_edge = e_cnt + 2;
        wait_cycles(3);
    endtask

    initial begin
        rx = 1'b1; rx_en = 1'b1; reset = 1'b1; clk_count_bit = 32'd16;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);
        check("reset_data", data, 8'h00);
        check("reset_flags", {valid, frame_err, overrun, busy_flag}, 4'b0000);

        // 0xA5: valid rises SYNC+1+half+9*n_bit = 155 edges after the start is driven.
        send_frame(8'hA5, 1'b1);
        wait_cycles(10);
        check("a5_data", data, 8'hA5);
        check("a5_flags", {valid, frame_err, overrun, busy_flag}, 4'b1000);
        check("a5_rise_edge", last_rise, sent_p + 155);
        ack_pulse();
        check("a5_ack_valid", valid, 1'b0);

        busy_seen = 1'b0;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(30);
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_flags", {valid, frame_err, overrun, busy_flag}, 4'b0000);

        send_frame(8'h3C, 1'b0);
        wait_cycles(10);
        check("bad_stop_ferr", frame_err, 1'b1);
        check("bad_stop_keep", {data, valid}, {8'hA5, 1'b0});
        send_frame(8'h55, 1'b1);
        wait_cycles(10);
        check("good_after_bad", {data, valid, frame_err}, {8'h55, 1'b1, 1'b0});
        ack_pulse();

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cycles(10);
        check("overrun_set", {data, valid, overrun}, {8'h22, 1'b1, 1'b1});
        ack_pulse();
        check("overrun_clear", {valid, overrun}, 2'b00);

        send_frame(8'h33, 1'b1);
        ack_edge = e_cnt + SYNC + 1 + half + 9 * n_bit;
        send_frame(8'h44, 1'b1);
        wait_cycles(10);
        check("ack_on_load", {data, valid, overrun}, {8'h44, 1'b1, 1'b0});
        ack_pulse();

        // 0xFF cut off by reset in the middle of its data bits.
        rx = 1'b0;
        wait_cycles(n_bit);
        rx = 1'b1;
        wait_cycles(3 * n_bit);
        check("mid_data_busy", busy_flag, 1'b1);
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(3);
        check("mid_reset_state", {data, valid, frame_err, overrun, busy_flag}, {8'h00, 4'b0000});
        wait_cycles(20);
        send_frame(8'h81, 1'b1);
        wait_cycles(10);
        check("after_reset_81", {data, valid}, {8'h81, 1'b1});
        ack_pulse();

        rx_en = 1'b0;
        busy_seen = 1'b0;
        send_frame(8'h7E, 1'b1);
        wait_cycles(10);
        check("rx_en_off_busy", busy_seen, 1'b0);
        check("rx_en_off_keep", {data, valid}, {8'h81, 1'b0});
        rx_en = 1'b1;
        wait_cycles(5);

        // Odd divisor: half-bit of 2 clocks.
        n_bit = 5; half = 2; clk_count_bit = 32'd5;
        wait_cycles(5);
        send_frame(8'hC3, 1'b1);
        wait_cycles(10);
        check("div5_c3", {data, valid}, {8'hC3, 1'b1});
        ack_pulse();

        rx = 1'b0;
        wait_cycles(20 * n_bit);
        check("break_flags", {valid, frame_err, busy_flag}, 3'b010);
        rx = 1'b1;
        wait_cycles(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
